// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared types for the pipelined barrel shifter.
// Shift modes and the per-stage register bundle.
package shifter_pkg;

   localparam int unsigned SHIFTER_W = 32;
   localparam int unsigned SHIFTER_N = $clog2(SHIFTER_W);

   typedef enum logic [1:0] {
      SHIFT_SLL = 2'b00,
      SHIFT_SRL = 2'b01,
      SHIFT_ROR = 2'b10,
      SHIFT_SRA = 2'b11
   } shift_mode_t;

   typedef struct packed {
      logic                 valid;
      logic [SHIFTER_W-1:0] data;
      logic [SHIFTER_N-1:0] shamt;
      shift_mode_t          mode;
   } stage_t;

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// Operand/result handshake bundle for the barrel shifter.
// master = upstream+downstream environment, slave = the shifter.
interface pipelined_barrel_shifter_if
   import shifter_pkg::*;
#(
   parameter int unsigned nb_bits_data = SHIFTER_W
);
   localparam int unsigned nb_bits_shamt = $clog2(nb_bits_data);

   logic                     valid_i;
   logic                     ready_o;
   logic [nb_bits_data-1:0]  data_i;
   logic [nb_bits_shamt-1:0] shamt_i;
   shift_mode_t              mode_i;
   logic                     valid_o;
   logic                     ready_i;
   logic [nb_bits_data-1:0]  data_o;

   modport master (
      output valid_i, data_i, shamt_i, mode_i, ready_i,
      input  ready_o, valid_o, data_o
   );

   modport slave (
      input  valid_i, data_i, shamt_i, mode_i, ready_i,
      output ready_o, valid_o, data_o
   );

endinterface

// File: rtl/pipelined_barrel_shifter_stage.sv
// One fixed-distance shift in all four modes.
// Passes the operand through unchanged when en is low.
module barrel_shift_stage
   import shifter_pkg::*;
#(
   parameter int unsigned nb_bits_data = 32,
   parameter int unsigned shift_value  = 1
) (
   input  logic                    en,
   input  shift_mode_t             mode,
   input  logic [nb_bits_data-1:0] operand,
   output logic [nb_bits_data-1:0] result
);
   localparam int unsigned W = nb_bits_data;
   localparam int unsigned S = shift_value;

   always_comb begin
      result = operand;
      if (en) begin
         unique case (mode)
            SHIFT_SLL: result = operand << S;
            SHIFT_SRL: result = operand >> S;
            SHIFT_SRA: result = {{S{operand[W-1]}}, operand[W-1:S]};
            SHIFT_ROR: result = {operand[S-1:0], operand[W-1:S]};
            default:   result = operand;
         endcase
      end
   end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// log2(W)-stage barrel shifter; stage k shifts by 2^k.
// The whole pipe advances together, so ready_o is just adv.
module pipelined_barrel_shifter
   import shifter_pkg::*;
#(
   parameter int unsigned nb_bits_data = SHIFTER_W
) (
   input logic clk_i,
   input logic rst_i,
   pipelined_barrel_shifter_if.slave bus
);
   localparam int unsigned nb_bits_shamt = $clog2(nb_bits_data);
   localparam int unsigned N = nb_bits_shamt;

   stage_t                  stage_q  [N];
   stage_t                  stage_in [N];
   stage_t                  stage_d  [N];
   logic [nb_bits_data-1:0] shifted  [N];
   logic                    adv;
   logic                    unused_tail;

   assign adv         = bus.ready_i | ~stage_q[N-1].valid;
   assign bus.ready_o = adv;
   assign bus.valid_o = stage_q[N-1].valid;
   assign bus.data_o  = stage_q[N-1].data;

   // shamt/mode are fully consumed by the last stage
   assign unused_tail = ^{stage_q[N-1].shamt, stage_q[N-1].mode};

   always_comb begin
      stage_in[0] = '{
         valid: bus.valid_i,
         data:  bus.data_i,
         shamt: bus.shamt_i,
         mode:  bus.mode_i
      };
      for (int k = 1; k < N; k++) begin
         stage_in[k] = stage_q[k-1];
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_stage
      barrel_shift_stage #(
         .nb_bits_data (nb_bits_data),
         .shift_value  (1 << k)
      ) u_stage (
         .en      (stage_in[k].shamt[k]),
         .mode    (stage_in[k].mode),
         .operand (stage_in[k].data),
         .result  (shifted[k])
      );
   end

   always_comb begin
      for (int k = 0; k < N; k++) begin
         stage_d[k]      = stage_in[k];
         stage_d[k].data = shifted[k];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < N; k++) begin
            stage_q[k] <= '0;
         end
      end else if (adv) begin
         for (int k = 0; k < N; k++) begin
            stage_q[k] <= stage_d[k];
         end
      end
   end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed + random bench for the pipelined barrel shifter.
// Scoreboard of expected results, popped as the DUT emits them.
module tb_pipelined_barrel_shifter;
   import shifter_pkg::*;

   logic clk = 1'b0;
   logic rst_i = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   bit   rec_pops = 1'b0;
   int   pop_cyc[$];
   logic [31:0] sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pipelined_barrel_shifter_if #(.nb_bits_data(32)) bus ();

   pipelined_barrel_shifter dut (
      .clk_i (clk),
      .rst_i (rst_i),
      .bus   (bus)
   );

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_model(logic [31:0] d,
                                             logic [4:0] s,
                                             shift_mode_t m);
      logic [31:0] r;
      r = d;
      for (int i = 0; i < 32; i++) begin
         if (i < int'(s)) begin
            case (m)
               SHIFT_SLL: r = {r[30:0], 1'b0};
               SHIFT_SRL: r = {1'b0, r[31:1]};
               SHIFT_SRA: r = {r[31], r[31:1]};
               default:   r = {r[0], r[31:1]};
            endcase
         end
      end
      return r;
   endfunction

   always @(negedge clk) begin
      if (!rst_i && bus.valid_o && bus.ready_i) begin
         if (sb.size() == 0) begin
            check("spurious_valid", 32'(bus.valid_o), 32'd0);
         end else begin
            check("result", bus.data_o, sb.pop_front());
            if (rec_pops) pop_cyc.push_back(cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(logic [31:0] d, logic [4:0] s,
                       shift_mode_t m, logic [31:0] exp);
      bit acc;
      acc = 1'b0;
      bus.valid_i = 1'b1;
      bus.data_i  = d;
      bus.shamt_i = s;
      bus.mode_i  = m;
      for (int n = 0; n < 100 && !acc; n++) begin
         @(negedge clk);
         acc = bus.ready_o;
         tick();
      end
      if (acc) sb.push_back(exp);
      else check("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_valid(string tag);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 50 && !seen; n++) begin
         @(negedge clk);
         seen = bus.valid_o;
         if (!seen) tick();
      end
      if (!seen) check(tag, 32'd0, 32'd1);
   endtask

   task automatic drain(string tag);
      for (int n = 0; n < 200 && sb.size() != 0; n++) tick();
      check(tag, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      logic [31:0] vd [8];
      logic [4:0]  vs [8];
      shift_mode_t vm [8];
      logic [31:0] ve [8];
      logic [31:0] rd;
      logic [4:0]  rs;
      shift_mode_t rm;
      int n, sent, loops;
      bit pend, acc;

      bus.valid_i = 1'b0;
      bus.data_i  = '0;
      bus.shamt_i = '0;
      bus.mode_i  = SHIFT_SLL;
      bus.ready_i = 1'b1;

      // reset state
      rst_i = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      check("rst_valid_o", 32'(bus.valid_o), 32'd0);
      check("rst_data_o", bus.data_o, 32'd0);
      check("rst_ready_o", 32'(bus.ready_o), 32'd1);
      tick();
      rst_i = 1'b0;

      // latency of a single op
      send(32'h0000_0001, 5'd31, SHIFT_SLL, 32'h8000_0000);
      bus.valid_i = 1'b0;
      n = 1;
      while (n < 20) begin
         @(negedge clk);
         if (bus.valid_o) break;
         tick();
         n++;
      end
      check("latency", 32'(n), 32'd5);
      drain("drain_latency");

      // 8 directed ops back to back
      vd = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000,
             32'h0000_0001, 32'h1234_5678, 32'h8765_4321, 32'hDEAD_BEEF};
      vs = '{5'd4, 5'd4, 5'd31, 5'd4, 5'd1, 5'd8, 5'd0, 5'd0};
      vm = '{SHIFT_SLL, SHIFT_SRA, SHIFT_SRA, SHIFT_SRL,
             SHIFT_ROR, SHIFT_ROR, SHIFT_SRA, SHIFT_ROR};
      ve = '{32'hFFFF_FFF0, 32'hF800_0000, 32'h0000_0000, 32'h0800_0000,
             32'h8000_0000, 32'h7812_3456, 32'h8765_4321, 32'hDEAD_BEEF};
      pop_cyc.delete();
      rec_pops = 1'b1;
      for (int i = 0; i < 8; i++) send(vd[i], vs[i], vm[i], ve[i]);
      bus.valid_i = 1'b0;
      drain("drain_b2b");
      rec_pops = 1'b0;
      check("b2b_count", 32'(pop_cyc.size()), 32'd8);
      for (int i = 1; i < pop_cyc.size(); i++) begin
         check("b2b_gap", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd1);
      end

      // back-pressure with junk offered while stalled
      bus.ready_i = 1'b0;
      send(32'h0000_00F0, 5'd8, SHIFT_SLL, 32'h0000_F000);
      send(32'hF000_0000, 5'd12, SHIFT_SRL, 32'h000F_0000);
      send(32'h0000_000F, 5'd4, SHIFT_ROR, 32'hF000_0000);
      bus.valid_i = 1'b0;
      wait_valid("bp_wait_valid");
      bus.valid_i = 1'b1;
      bus.data_i  = 32'hBAD0_BAD0;
      bus.shamt_i = 5'd3;
      for (int i = 0; i < 3; i++) begin
         check("bp_valid_o", 32'(bus.valid_o), 32'd1);
         check("bp_ready_o", 32'(bus.ready_o), 32'd0);
         check("bp_data_o", bus.data_o, 32'h0000_F000);
         tick();
         @(negedge clk);
      end
      tick();
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b1;
      drain("drain_bp");
      repeat (8) tick();

      // reset with ops in flight and one parked at the output
      bus.ready_i = 1'b0;
      send(32'h1111_1111, 5'd1, SHIFT_SLL, 32'h2222_2222);
      send(32'h2222_2222, 5'd2, SHIFT_SRL, 32'h0888_8888);
      send(32'h3333_3333, 5'd3, SHIFT_ROR, 32'h6666_6666);
      bus.valid_i = 1'b0;
      wait_valid("rst_wait_valid");
      tick();
      rst_i = 1'b1;
      sb.delete();
      tick();
      rst_i = 1'b0;
      @(negedge clk);
      check("midrst_valid_o", 32'(bus.valid_o), 32'd0);
      check("midrst_ready_o", 32'(bus.ready_o), 32'd1);
      tick();
      bus.ready_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("midrst_no_stale", 32'(bus.valid_o), 32'd0);
         tick();
      end

      // random traffic
      sent = 0;
      loops = 0;
      pend = 1'b0;
      while (sent < 10000 && loops < 60000) begin
         if (!pend && $urandom_range(0, 4) != 0) begin
            rd = $urandom;
            rs = 5'($urandom_range(0, 31));
            rm = shift_mode_t'($urandom_range(0, 3));
            bus.valid_i = 1'b1;
            bus.data_i  = rd;
            bus.shamt_i = rs;
            bus.mode_i  = rm;
            pend = 1'b1;
         end
         bus.ready_i = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc = bus.valid_i && bus.ready_o;
         tick();
         loops++;
         if (acc) begin
            sb.push_back(ref_model(rd, rs, rm));
            sent++;
            pend = 1'b0;
            bus.valid_i = 1'b0;
         end
      end
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b1;
      check("random_sent", 32'(sent), 32'd10000);
      drain("drain_random");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
